// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch-stage bus bundle (pipeline control, byte memory port, IF/ID output).
// master = fetch stage, slave = pipeline/memory side.
interface inst_fetch_if;
  logic        rdy;
  logic [31:0] pc_i;
  logic [5:0]  stall_sign;
  logic        branch_enable_i;
  logic        mem_req_o;
  logic        mem_grant_i;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stall_req_o;
  modport master (
    input  rdy, pc_i, stall_sign, branch_enable_i, mem_grant_i, mem_data_i,
    output mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o
  );
  modport slave (
    output rdy, pc_i, stall_sign, branch_enable_i, mem_grant_i, mem_data_i,
    input  mem_req_o, mem_addr_o, inst_o, inst_pc_o, inst_valid_o, stall_req_o
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I fetch stage assembling each instruction from four byte reads.
// Define IF_ICACHE_EN for a 16-entry direct-mapped instruction cache.
module inst_fetch (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RD0, S_RD1, S_RD2, S_RD3, S_RD4, S_DONE} state_t;
  state_t      r_state;
  logic [31:0] r_fetch_pc, r_inst, r_inst_pc, r_addr;
  logic [23:0] r_bytes;
  logic        r_req, r_valid;
  logic        w_hit;
  logic [31:0] w_hit_inst;
  logic        w_unused;
  assign w_unused = ^{bus.stall_sign[5:2], bus.stall_sign[0]};
`ifdef IF_ICACHE_EN
  logic [25:0] r_tag [16];
  logic [31:0] r_data [16];
  logic [15:0] r_cv;
  logic [3:0]  w_idx, w_fidx;
  logic        w_fill;
  assign w_idx      = bus.pc_i[5:2];
  assign w_fidx     = r_fetch_pc[5:2];
  assign w_hit      = r_cv[w_idx] && r_tag[w_idx] == bus.pc_i[31:6];
  assign w_hit_inst = r_data[w_idx];
  // A redirect in RD4 discards the fetch, so it must not fill either.
  assign w_fill     = bus.rdy && !bus.branch_enable_i && r_state == S_RD4;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cv <= '0;
    else if (w_fill) r_cv[w_fidx] <= 1'b1;
  always_ff @(posedge clk)
    if (w_fill) begin
      r_tag[w_fidx]  <= r_fetch_pc[31:6];
      r_data[w_fidx] <= {bus.mem_data_i, r_bytes};
    end
`else
  assign w_hit      = 1'b0;
  assign w_hit_inst = '0;
`endif
  // Bytes shift in from the top, so after RD3 r_bytes holds {b2, b1, b0}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_bytes    <= '0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
      r_addr     <= '0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
    end else if (bus.branch_enable_i) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
    end else if (bus.rdy) begin
      case (r_state)
        S_IDLE:
          if (w_hit) begin
            r_inst    <= w_hit_inst;
            r_inst_pc <= bus.pc_i;
            r_valid   <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_fetch_pc <= bus.pc_i;
            r_req      <= 1'b1;
            r_state    <= S_WAIT;
          end
        S_WAIT:
          if (bus.mem_grant_i) begin
            r_addr  <= r_fetch_pc;
            r_state <= S_RD0;
          end
        S_RD0: begin
          r_addr  <= r_fetch_pc + 32'd1;
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_bytes <= {bus.mem_data_i, r_bytes[23:8]};
          r_addr  <= r_fetch_pc + 32'd2;
          r_state <= S_RD2;
        end
        S_RD2: begin
          r_bytes <= {bus.mem_data_i, r_bytes[23:8]};
          r_addr  <= r_fetch_pc + 32'd3;
          r_state <= S_RD3;
        end
        S_RD3: begin
          r_bytes <= {bus.mem_data_i, r_bytes[23:8]};
          r_addr  <= '0;
          r_req   <= 1'b0;
          r_state <= S_RD4;
        end
        S_RD4: begin
          r_inst    <= {bus.mem_data_i, r_bytes};
          r_inst_pc <= r_fetch_pc;
          r_valid   <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE:
          if (!bus.stall_sign[1]) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
      endcase
    end
  end
  assign bus.mem_req_o    = r_req;
  assign bus.mem_addr_o   = r_addr;
  assign bus.inst_o       = r_inst;
  assign bus.inst_pc_o    = r_inst_pc;
  assign bus.inst_valid_o = r_valid;
  assign bus.stall_req_o  = r_state != S_DONE;
endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage for the RV32I pipeline. Consumes the program counter from the PC register, reads the 32-bit instruction through the byte-wide memory controller port as four single-byte reads, and presents the assembled instruction with its PC to the IF/ID latch. While a fetch is in progress it raises a stall request so the PC holds, and it aborts on a branch redirect.

## Interface
- No parameters. Cache geometry is fixed: 16 entries, direct-mapped.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rdy` input 1: global ready; low freezes the block.
- `pc_i` input 32: current PC from the PC register.
- `stall_sign` input 6: stall vector from the pipeline controller; bit 1 high means IF/ID cannot accept.
- `branch_enable_i` input 1: branch redirect; flushes the fetch.
- `mem_req_o` output 1: request for the memory port.
- `mem_grant_i` input 1: arbiter grant. Once granted, the grant is held until `mem_req_o` drops.
- `mem_addr_o` output 32: byte address to memory.
- `mem_data_i` input 8: read byte. Valid one cycle after its address.
- `inst_o` output 32: fetched instruction.
- `inst_pc_o` output 32: PC of `inst_o`.
- `inst_valid_o` output 1: `inst_o` and `inst_pc_o` are valid.
- `stall_req_o` output 1: asks the controller to stall the PC and IF.

## Operation
- States: IDLE, WAIT, RD0, RD1, RD2, RD3, RD4, DONE.
- **IDLE**
  - On a cache hit (with `IF_ICACHE_EN`): load `inst_o` from the cache, load `inst_pc_o` with `pc_i`, go to DONE.
  - Otherwise: latch `pc_i` into `fetch_pc`, go to WAIT.
- **WAIT**
  - `mem_req_o` is 1.
  - Go to RD0 when `mem_grant_i` is 1. Otherwise stay in WAIT.
- **RDk (k = 0..3)**
  - `mem_req_o` is 1.
  - `mem_addr_o` = `fetch_pc` + k. The sum is 32-bit and wraps modulo 2^32.
- **Byte capture**
  - RD1, RD2 and RD3 capture byte k-1 from `mem_data_i`.
  - RD4 captures byte 3 and sets `inst_o` = {b3, b2, b1, b0} (little-endian).
  - RD4 also loads `inst_pc_o` with `fetch_pc`, writes the cache, and goes to DONE.
  - In RD4 `mem_req_o` is 0.
- **Idle outputs:** outside RD0..RD3, `mem_addr_o` is 0.
- **DONE**
  - `inst_valid_o` is 1.
  - If `stall_sign[1]` is 0, go to IDLE. Otherwise hold with outputs unchanged.
- **Stall request:** `stall_req_o` = (state != DONE), combinational.
- **Valid flag:** `inst_valid_o` is registered and is 1 only in DONE.
- **Branch redirect:** `branch_enable_i` = 1 in any state forces IDLE on the next edge.
  - `inst_valid_o` goes to 0 and `mem_req_o` drops.
  - The partial instruction is discarded and the cache is not written.
  - Branch takes priority over `rdy`.
- **`rdy` = 0:** every register holds. Only reset and branch act.
- **Reset values:**
  - State IDLE.
  - `inst_o`, `inst_pc_o`, `inst_valid_o`, `mem_req_o`, `mem_addr_o` all 0.
  - `stall_req_o` is 1.
  - All cache valid bits cleared.

## Timing
- Uncontended miss, with the launch in IDLE at cycle T:
  - WAIT at T+1.
  - RD0–RD3 at T+2..T+5, with addresses pc, pc+1, pc+2, pc+3.
  - RD4 at T+6.
  - DONE at T+7, with `inst_valid_o` = 1 and `stall_req_o` = 0.
- Every cycle without grant in WAIT adds one cycle.
- Cache hit: DONE at T+1.
- The PC advances on the edge that leaves DONE. IDLE on the next cycle sees pc+4.
- Throughput:
  - Miss: 1 instruction per 8 cycles.
  - Hit: 1 instruction per 2 cycles.

## Configuration
- **`IF_ICACHE_EN` defined:** 16-entry direct-mapped instruction cache.
  - Index is `pc[5:2]`; tag is `pc[31:6]`; one valid bit per entry.
  - Lookup happens in IDLE.
  - Fill happens in RD4 and overwrites any entry with a different tag.
- **`IF_ICACHE_EN` undefined:** no cache storage. Every fetch takes the miss path.

## Test plan
- Miss path:
  - Stimulus: reset released, `pc_i` = 0x0, grant immediate, memory bytes 0x13 0x00 0x00 0x00.
  - Required: `mem_addr_o` = 0, 1, 2, 3 at T+2..T+5, then at T+7 `inst_o` = 0x00000013, `inst_pc_o` = 0, valid = 1, `stall_req_o` = 0.
- Grant delay:
  - Stimulus: grant withheld for 3 WAIT cycles.
  - Required: `mem_req_o` stays 1, `mem_addr_o` stays 0, RD0 at T+5, DONE at T+10.
- Branch mid-fetch:
  - Stimulus: `branch_enable_i` asserted in RD2.
  - Required: IDLE next cycle, no valid pulse, next fetch uses the new `pc_i`, and (with cache) a re-fetch of the old PC misses.
- Downstream stall:
  - Stimulus: `stall_sign[1]` = 1 for 2 cycles while in DONE.
  - Required: valid held 3 cycles with `inst_o` unchanged, then IDLE.
- `rdy` freeze:
  - Stimulus: `rdy` = 0 for 4 cycles in RD1.
  - Required: state and `mem_addr_o` = pc+1 held, and the fetch completes with the correct instruction.
- Cache behaviour (`IF_ICACHE_EN`):
  - Stimulus: fetch PC 0x10, then fetch 0x10 again, then fetch 0x50.
  - Required: the second fetch of 0x10 is valid at T+1 with no `mem_req_o`. 0x50 (same index, different tag) misses and replaces the entry.
